// File: rtl/hazard_sched.sv
// hazard_sched -- stall and forwarding scheduler for a 5-stage MIPS pipeline
// (F/D/E/M/W).
//
// The D-stage instruction is decoded into its source operands, their Tuse,
// its destination register (A3) and its Tnew. A3/Tnew and the source fields
// then travel down E, M and W inside this block. From that state the block
// drives the global stall and every bypass mux select. It also runs a busy
// counter for the multiply/divide unit and holds HI/LO-class instructions
// in D while that unit is busy.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   reset     in   1   asynchronous reset, active low
//   IR_D      in  32   instruction currently in D
//   stall     out  1   freeze PC and D, inject a bubble into E
//   fwd_rs_d  out  2   D rs bypass: 0 GRF, 1 E (jal PC+8), 2 M, 3 W
//   fwd_rt_d  out  2   D rt bypass, same encoding
//   fwd_rs_e  out  2   E rs bypass: 0 pipeline reg, 2 M, 3 W
//   fwd_rt_e  out  2   E rt bypass, same encoding
//   fwd_rt_m  out  1   M rt (sw data) bypass: 0 pipeline reg, 1 W
//   md_busy   out  1   multiply/divide unit busy
module hazard_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4    // must be wide enough to hold DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_D,
    output logic        stall,
    output logic [1:0]  fwd_rs_d,
    output logic [1:0]  fwd_rt_d,
    output logic [1:0]  fwd_rs_e,
    output logic [1:0]  fwd_rt_e,
    output logic        fwd_rt_m,
    output logic        md_busy
);

    typedef enum logic [3:0] {
        I_NOP, I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ,
        I_J, I_JAL, I_JR, I_MULT, I_DIV, I_MFHI, I_MFLO
    } instr_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_MULT = 6'h18;
    localparam logic [5:0] F_DIV  = 6'h1a;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;

    // ------------------------------------------------------------------
    // D-stage decode
    // ------------------------------------------------------------------
    logic [5:0] op, func;
    logic [4:0] rs, rt, rd;
    logic       unused_shamt;

    assign op           = IR_D[31:26];
    assign rs           = IR_D[25:21];
    assign rt           = IR_D[20:16];
    assign rd           = IR_D[15:11];
    assign func         = IR_D[5:0];
    assign unused_shamt = ^IR_D[10:6];

    instr_e d_cls;

    // NOTE: every signal written in an always_comb gets a default on the
    // first line. Then no path through the case tree can leave it unassigned,
    // so no latch is inferred.
    always_comb begin
        d_cls = I_NOP;
        if (op == OP_SPECIAL) begin
            case (func)
                F_ADDU:  d_cls = I_ADDU;
                F_SUBU:  d_cls = I_SUBU;
                F_JR:    d_cls = I_JR;
                F_MULT:  d_cls = I_MULT;
                F_DIV:   d_cls = I_DIV;
                F_MFHI:  d_cls = I_MFHI;
                F_MFLO:  d_cls = I_MFLO;
                default: d_cls = I_NOP;
            endcase
        end else begin
            case (op)
                OP_ORI:  d_cls = I_ORI;
                OP_LUI:  d_cls = I_LUI;
                OP_LW:   d_cls = I_LW;
                OP_SW:   d_cls = I_SW;
                OP_BEQ:  d_cls = I_BEQ;
                OP_J:    d_cls = I_J;
                OP_JAL:  d_cls = I_JAL;
                default: d_cls = I_NOP;
            endcase
        end
    end

    // A source the instruction does not read is reported as register 0.
    // Register 0 never matches, so an unread source imposes no constraint
    // and never forwards.
    logic [4:0] d_rs, d_rt, d_a3;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;

    always_comb begin
        d_rs      = 5'd0;
        d_rt      = 5'd0;
        d_tuse_rs = 2'd0;
        d_tuse_rt = 2'd0;
        d_a3      = 5'd0;
        d_tnew    = 2'd0;
        case (d_cls)
            I_ADDU, I_SUBU: begin
                d_rs = rs; d_tuse_rs = 2'd1;
                d_rt = rt; d_tuse_rt = 2'd1;
                d_a3 = rd; d_tnew    = 2'd1;
            end
            I_ORI: begin
                d_rs = rs; d_tuse_rs = 2'd1;
                d_a3 = rt; d_tnew    = 2'd1;
            end
            I_LUI: begin
                d_a3 = rt; d_tnew = 2'd1;
            end
            I_LW: begin
                d_rs = rs; d_tuse_rs = 2'd1;
                d_a3 = rt; d_tnew    = 2'd2;
            end
            I_SW: begin
                d_rs = rs; d_tuse_rs = 2'd1;
                d_rt = rt; d_tuse_rt = 2'd2;
            end
            I_BEQ: begin
                d_rs = rs; d_tuse_rs = 2'd0;
                d_rt = rt; d_tuse_rt = 2'd0;
            end
            I_JR: begin
                d_rs = rs; d_tuse_rs = 2'd0;
            end
            I_JAL: begin
                d_a3 = 5'd31; d_tnew = 2'd0;
            end
            I_MULT, I_DIV: begin
                d_rs = rs; d_tuse_rs = 2'd1;
                d_rt = rt; d_tuse_rt = 2'd1;
            end
            I_MFHI, I_MFLO: begin
                d_a3 = rd; d_tnew = 2'd1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-stage state carried down the pipe
    // ------------------------------------------------------------------
    logic [4:0]       e_a3, e_rs, e_rt, m_a3, m_rt, w_a3;
    logic [1:0]       e_tnew, m_tnew, w_tnew;
    logic [CNT_W-1:0] md_cnt;

    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // A producer in stage X blocks a D consumer only if its result is not
    // ready by the time the consumer needs it (Tnew > Tuse).
    function automatic logic raw_block(input logic [4:0] src, input logic [1:0] tuse,
                                       input logic [4:0] a3,  input logic [1:0] tnew);
        return (src != 5'd0) && (src == a3) && (tnew > tuse);
    endfunction

    // A stage can supply a bypass only once its result exists (Tnew = 0).
    function automatic logic fwd_hit(input logic [4:0] src, input logic [4:0] a3,
                                     input logic [1:0] tnew);
        return (tnew == 2'd0) && (a3 != 5'd0) && (a3 == src);
    endfunction

    // ------------------------------------------------------------------
    // Stall
    // ------------------------------------------------------------------
    logic d_is_md, d_md_start, reg_stall, md_stall;

    assign d_is_md  = (d_cls == I_MULT) || (d_cls == I_DIV) ||
                      (d_cls == I_MFHI) || (d_cls == I_MFLO);
    assign md_busy  = (md_cnt != '0);
    assign md_stall = d_is_md && md_busy;

    assign reg_stall = raw_block(d_rs, d_tuse_rs, e_a3, e_tnew) ||
                       raw_block(d_rt, d_tuse_rt, e_a3, e_tnew) ||
                       raw_block(d_rs, d_tuse_rs, m_a3, m_tnew) ||
                       raw_block(d_rt, d_tuse_rt, m_a3, m_tnew);

    assign stall = reg_stall || md_stall;

    // The counter loads only on the edge where mult/div actually leaves D.
    assign d_md_start = ((d_cls == I_MULT) || (d_cls == I_DIV)) && !stall;

    // ------------------------------------------------------------------
    // Bypass selects: youngest ready producer wins (E > M > W)
    // ------------------------------------------------------------------
    always_comb begin
        fwd_rs_d = 2'd0;
        if      (fwd_hit(d_rs, e_a3, e_tnew)) fwd_rs_d = 2'd1;
        else if (fwd_hit(d_rs, m_a3, m_tnew)) fwd_rs_d = 2'd2;
        else if (fwd_hit(d_rs, w_a3, w_tnew)) fwd_rs_d = 2'd3;

        fwd_rt_d = 2'd0;
        if      (fwd_hit(d_rt, e_a3, e_tnew)) fwd_rt_d = 2'd1;
        else if (fwd_hit(d_rt, m_a3, m_tnew)) fwd_rt_d = 2'd2;
        else if (fwd_hit(d_rt, w_a3, w_tnew)) fwd_rt_d = 2'd3;

        fwd_rs_e = 2'd0;
        if      (fwd_hit(e_rs, m_a3, m_tnew)) fwd_rs_e = 2'd2;
        else if (fwd_hit(e_rs, w_a3, w_tnew)) fwd_rs_e = 2'd3;

        fwd_rt_e = 2'd0;
        if      (fwd_hit(e_rt, m_a3, m_tnew)) fwd_rt_e = 2'd2;
        else if (fwd_hit(e_rt, w_a3, w_tnew)) fwd_rt_e = 2'd3;

        fwd_rt_m = fwd_hit(m_rt, w_a3, w_tnew);
    end

    // ------------------------------------------------------------------
    // Stage shift and multiply/divide busy counter
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. All right-hand
    // sides are sampled before any register updates, so M really captures
    // the old E and W captures the old M.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_a3   <= 5'd0;
            e_rs   <= 5'd0;
            e_rt   <= 5'd0;
            e_tnew <= 2'd0;
            m_a3   <= 5'd0;
            m_rt   <= 5'd0;
            m_tnew <= 2'd0;
            w_a3   <= 5'd0;
            w_tnew <= 2'd0;
            md_cnt <= '0;
        end else begin
            if (stall) begin
                e_a3   <= 5'd0;
                e_rs   <= 5'd0;
                e_rt   <= 5'd0;
                e_tnew <= 2'd0;
            end else begin
                e_a3   <= d_a3;
                e_rs   <= d_rs;
                e_rt   <= d_rt;
                e_tnew <= d_tnew;
            end
            m_a3   <= e_a3;
            m_rt   <= e_rt;
            m_tnew <= tnew_dec(e_tnew);
            w_a3   <= m_a3;
            w_tnew <= tnew_dec(m_tnew);

            if (d_md_start)
                md_cnt <= (d_cls == I_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched. Instructions are generated as
// mnemonics and assembled into IR_D. A reference model tracks the in-flight
// instructions by mnemonic semantics: per-slot entry Tnew aged by the
// slot's distance from E, plus a remaining-busy count for the mult/div unit.
module tb_hazard_sched;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_D;
    logic        stall;
    logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic        fwd_rt_m;
    logic        md_busy;

    hazard_sched #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .IR_D    (IR_D),
        .stall   (stall),
        .fwd_rs_d(fwd_rs_d),
        .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e),
        .fwd_rt_e(fwd_rt_e),
        .fwd_rt_m(fwd_rt_m),
        .md_busy (md_busy)
    );

    always #5 clk = ~clk;

    typedef enum int {
        M_NOP, M_ADDU, M_SUBU, M_ORI, M_LUI, M_LW, M_SW, M_BEQ,
        M_J, M_JAL, M_JR, M_MULT, M_DIV, M_MFHI, M_MFLO
    } mn_e;

    typedef struct {
        mn_e         mn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] fill;   // random bits for fields the mnemonic leaves free
    } ins_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- instruction construction ----------------
    function automatic ins_t mk(input mn_e m, input int s, input int t, input int d);
        ins_t x;
        x.mn   = m;
        x.rs   = 5'(s);
        x.rt   = 5'(t);
        x.rd   = 5'(d);
        x.fill = $urandom;
        return x;
    endfunction

    function automatic ins_t zero_nop();
        ins_t x;
        x = mk(M_NOP, 0, 0, 0);
        x.fill = 32'd0;
        return x;
    endfunction

    function automatic logic [31:0] enc(input ins_t x);
        logic [31:0] r;
        r = {6'h00, x.rs, x.rt, x.rd, x.fill[10:6], 6'h00};
        case (x.mn)
            M_ADDU: r[5:0] = 6'h21;
            M_SUBU: r[5:0] = 6'h23;
            M_JR:   r[5:0] = 6'h08;
            M_MULT: r[5:0] = 6'h18;
            M_DIV:  r[5:0] = 6'h1a;
            M_MFHI: r[5:0] = 6'h10;
            M_MFLO: r[5:0] = 6'h12;
            M_ORI:  r = {6'h0d, x.rs, x.rt, x.fill[15:0]};
            M_LUI:  r = {6'h0f, x.rs, x.rt, x.fill[15:0]};
            M_LW:   r = {6'h23, x.rs, x.rt, x.fill[15:0]};
            M_SW:   r = {6'h2b, x.rs, x.rt, x.fill[15:0]};
            M_BEQ:  r = {6'h04, x.rs, x.rt, x.fill[15:0]};
            M_J:    r = {6'h02, x.fill[25:0]};
            M_JAL:  r = {6'h03, x.fill[25:0]};
            default: begin
                // nop: all-zero word or an encoding outside the class set
                case (x.fill[1:0])
                    2'd0:    r = 32'h0;
                    2'd1:    r = {6'h3f, x.fill[25:0]};
                    2'd2:    r = {6'h00, x.fill[25:6], 6'h3f};
                    default: r = {6'h00, x.fill[25:6], 6'h01};
                endcase
            end
        endcase
        return r;
    endfunction

    // ---------------- reference model ----------------
    // Slot 0 = E, 1 = M, 2 = W. ptn holds Tnew on entry to E; the current
    // Tnew is that value minus the slot's age, floored at 0.
    int pa3[3], ptn[3], prs[3], prt[3];
    int md_rem;
    int x_stall, x_busy, x_frd, x_frtd, x_fre, x_frte, x_frm;
    ins_t cur;

    // Source registers (0 = not read), their Tuse, and the destination and
    // Tnew of each mnemonic.
    function automatic void info(input ins_t x, output int s, output int ts,
                                 output int t, output int tt, output int a3, output int tn);
        s = 0; ts = 0; t = 0; tt = 0; a3 = 0; tn = 0;
        case (x.mn)
            M_ADDU, M_SUBU: begin s = x.rs; ts = 1; t = x.rt; tt = 1; a3 = x.rd; tn = 1; end
            M_ORI:          begin s = x.rs; ts = 1; a3 = x.rt; tn = 1; end
            M_LUI:          begin a3 = x.rt; tn = 1; end
            M_LW:           begin s = x.rs; ts = 1; a3 = x.rt; tn = 2; end
            M_SW:           begin s = x.rs; ts = 1; t = x.rt; tt = 2; end
            M_BEQ:          begin s = x.rs; ts = 0; t = x.rt; tt = 0; end
            M_JR:           begin s = x.rs; ts = 0; end
            M_JAL:          begin a3 = 31; tn = 0; end
            M_MULT, M_DIV:  begin s = x.rs; ts = 1; t = x.rt; tt = 1; end
            M_MFHI, M_MFLO: begin a3 = x.rd; tn = 1; end
            default: ;
        endcase
    endfunction

    function automatic int cur_tn(input int i);
        int t;
        t = ptn[i] - i;
        return (t < 0) ? 0 : t;
    endfunction

    // First ready producer of src, searching from slot 'first' toward W.
    // The result is slot+1, which is also the bypass code.
    function automatic int fsel(input int src, input int first);
        if (src == 0) return 0;
        for (int i = first; i < 3; i++)
            if (pa3[i] == src && cur_tn(i) == 0) return i + 1;
        return 0;
    endfunction

    function automatic void calc(input ins_t x);
        int s, ts, t, tt, a3, tn;
        bit hz, is_md;
        info(x, s, ts, t, tt, a3, tn);
        hz = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (s != 0 && s == pa3[i] && cur_tn(i) > ts) hz = 1'b1;
            if (t != 0 && t == pa3[i] && cur_tn(i) > tt) hz = 1'b1;
        end
        is_md   = (x.mn == M_MULT) || (x.mn == M_DIV) || (x.mn == M_MFHI) || (x.mn == M_MFLO);
        x_busy  = (md_rem > 0) ? 1 : 0;
        x_stall = (hz || (is_md && md_rem > 0)) ? 1 : 0;
        x_frd   = fsel(s, 0);
        x_frtd  = fsel(t, 0);
        x_fre   = fsel(prs[0], 1);
        x_frte  = fsel(prt[0], 1);
        x_frm   = (fsel(prt[1], 2) != 0) ? 1 : 0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            pa3[i] = 0; ptn[i] = 0; prs[i] = 0; prt[i] = 0;
        end
        md_rem = 0;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge: apply IR_D, then wait to the falling
    // edge where outputs are sampled.
    task automatic drive(input ins_t x);
        cur  = x;
        IR_D = enc(x);
        @(negedge clk);
    endtask

    // Compare all outputs with the model, then cross the rising edge and
    // advance the model.
    task automatic tick();
        int s, ts, t, tt, a3, tn;
        calc(cur);
        check("stall",    stall,    x_stall);
        check("md_busy",  md_busy,  x_busy);
        check("fwd_rs_d", fwd_rs_d, x_frd);
        check("fwd_rt_d", fwd_rt_d, x_frtd);
        check("fwd_rs_e", fwd_rs_e, x_fre);
        check("fwd_rt_e", fwd_rt_e, x_frte);
        check("fwd_rt_m", fwd_rt_m, x_frm);
        @(posedge clk);
        info(cur, s, ts, t, tt, a3, tn);
        for (int i = 2; i > 0; i--) begin
            pa3[i] = pa3[i-1]; ptn[i] = ptn[i-1]; prs[i] = prs[i-1]; prt[i] = prt[i-1];
        end
        if (x_stall != 0) begin
            pa3[0] = 0; ptn[0] = 0; prs[0] = 0; prt[0] = 0;
        end else begin
            pa3[0] = a3; ptn[0] = tn; prs[0] = s; prt[0] = t;
        end
        if (x_stall == 0 && cur.mn == M_MULT)     md_rem = MULT_CYCLES;
        else if (x_stall == 0 && cur.mn == M_DIV) md_rem = DIV_CYCLES;
        else if (md_rem > 0)                      md_rem--;
        #1;
    endtask

    task automatic flush();
        repeat (3) begin
            drive(mk(M_NOP, 0, 0, 0));
            tick();
        end
    endtask

    function automatic int rreg();
        int k;
        k = $urandom_range(0, 7);
        case (k)
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 3;
            4: return 31;
            default: return $urandom_range(0, 31);
        endcase
    endfunction

    function automatic ins_t rand_ins();
        mn_e m;
        m = mn_e'($urandom_range(0, 14));
        // keep long mult/div stalls from dominating the random phase
        if ((m == M_MULT || m == M_DIV) && $urandom_range(0, 3) != 0) m = M_ADDU;
        return mk(m, rreg(), rreg(), rreg());
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        ins_t x;
        reset = 1'b0;
        IR_D  = 32'h0;
        cur   = zero_nop();
        model_reset();

        #7;
        check("rst_stall",    stall,    0);
        check("rst_md_busy",  md_busy,  0);
        check("rst_fwd_rs_d", fwd_rs_d, 0);
        check("rst_fwd_rt_d", fwd_rt_d, 0);
        check("rst_fwd_rs_e", fwd_rs_e, 0);
        check("rst_fwd_rt_e", fwd_rt_e, 0);
        check("rst_fwd_rt_m", fwd_rt_m, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // lw $1,0($0) ; addu $2,$1,$1 -> one-cycle load-use stall, then W bypass in E
        flush();
        drive(mk(M_LW, 0, 1, 0));    tick();
        drive(mk(M_ADDU, 1, 1, 2));  check("lw_use_stall", stall, 1); tick();
        drive(mk(M_ADDU, 1, 1, 2));  check("lw_use_go", stall, 0);    tick();
        drive(mk(M_NOP, 0, 0, 0));
        check("lw_w_fwd_rs_e", fwd_rs_e, 3);
        check("lw_w_fwd_rt_e", fwd_rt_e, 3);
        tick();

        // addu $3,$1,$2 ; beq $3,$3 -> one stall, then bypass from M
        flush();
        drive(mk(M_ADDU, 1, 2, 3));  tick();
        drive(mk(M_BEQ, 3, 3, 0));   check("beq_stall", stall, 1); tick();
        drive(mk(M_BEQ, 3, 3, 0));
        check("beq_go",       stall,    0);
        check("beq_fwd_rs_d", fwd_rs_d, 2);
        check("beq_fwd_rt_d", fwd_rt_d, 2);
        tick();

        // jal ; jr $31 -> bypass from E, then from M
        flush();
        drive(mk(M_JAL, 0, 0, 0));   tick();
        drive(mk(M_JR, 31, 0, 0));
        check("jr_no_stall", stall,    0);
        check("jr_fwd_e",    fwd_rs_d, 1);
        tick();
        drive(mk(M_JR, 31, 0, 0));   check("jr_fwd_m", fwd_rs_d, 2); tick();

        // writes to $0 never match; sw data bypass E<-M then M<-W
        flush();
        drive(mk(M_ORI, 0, 0, 0));   tick();
        drive(mk(M_BEQ, 0, 0, 0));
        check("r0_stall",    stall,    0);
        check("r0_fwd_rs_d", fwd_rs_d, 0);
        check("r0_fwd_rt_d", fwd_rt_d, 0);
        tick();
        drive(mk(M_ADDU, 1, 2, 4));  tick();
        drive(mk(M_SW, 0, 4, 0));    check("sw_no_stall", stall, 0); tick();
        drive(mk(M_NOP, 0, 0, 0));   check("sw_fwd_rt_e", fwd_rt_e, 2); tick();
        drive(mk(M_NOP, 0, 0, 0));   check("sw_fwd_rt_m", fwd_rt_m, 1); tick();

        // mult ; mflo -> 5 busy/stall cycles, mflo issues on the 6th
        flush();
        drive(mk(M_MULT, 1, 2, 0));  check("mult_issue", stall, 0); tick();
        for (int k = 0; k < 6; k++) begin
            drive(mk(M_MFLO, 0, 0, 5));
            check("mflo_stall", stall,   (k < 5) ? 1 : 0);
            check("mflo_busy",  md_busy, (k < 5) ? 1 : 0);
            tick();
        end

        // div ; div -> second div waits 10 cycles
        drive(mk(M_DIV, 1, 2, 0));   check("div1_issue", stall, 0); tick();
        for (int k = 0; k < 11; k++) begin
            drive(mk(M_DIV, 3, 1, 0));
            check("div2_stall", stall, (k < 10) ? 1 : 0);
            tick();
        end

        // reset asserted mid-div with mfhi stalled in D
        repeat (3) begin
            drive(mk(M_MFHI, 0, 0, 6));
            tick();
        end
        drive(mk(M_MFHI, 0, 0, 6));
        check("mid_div_busy",  md_busy, 1);
        check("mid_div_stall", stall,   1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_busy",  md_busy, 0);
        check("async_rst_stall", stall,   0);
        model_reset();
        cur  = zero_nop();
        IR_D = 32'h0;
        #1;
        check("rst_ir0_stall",    stall,    0);
        check("rst_ir0_fwd_rs_d", fwd_rs_d, 0);
        check("rst_ir0_fwd_rs_e", fwd_rs_e, 0);
        check("rst_ir0_fwd_rt_m", fwd_rt_m, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        drive(zero_nop());
        check("post_rst_fwd_rs_d", fwd_rs_d, 0);
        check("post_rst_fwd_rt_d", fwd_rt_d, 0);
        check("post_rst_fwd_rs_e", fwd_rs_e, 0);
        check("post_rst_fwd_rt_e", fwd_rt_e, 0);
        check("post_rst_fwd_rt_m", fwd_rt_m, 0);
        tick();

        // random instruction streams; a stalled instruction is held in D
        for (int n = 0; n < 600; n++) begin
            if (x_stall != 0) x = cur;
            else              x = rand_ins();
            drive(x);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Centralised stall and forwarding scheduler for the 5-stage MIPS pipeline (F/D/E/M/W).
- Decodes the D-stage instruction into source operands, Tuse, destination register (A3) and Tnew, and carries A3/Tnew/source fields down E, M and W internally.
- Drives the global stall and every bypass mux select.
- Also sequences the multiply/divide unit with a busy counter and stalls HI/LO-class instructions while that unit is busy.

Parameters:
- MULT_CYCLES, 5, busy cycles loaded for mult.
- DIV_CYCLES, 10, busy cycles loaded for div.
- CNT_W, 4, busy counter width; must hold DIV_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- IR_D  in  32  instruction currently in D stage.
- stall  out  1  1 = freeze PC and D register, inject bubble into E.
- fwd_rs_d  out  2  D-stage rs bypass: 0 = GRF, 1 = E (PC+8 of jal), 2 = M, 3 = W.
- fwd_rt_d  out  2  D-stage rt bypass, same encoding.
- fwd_rs_e  out  2  E-stage rs bypass: 0 = pipeline reg, 2 = M, 3 = W.
- fwd_rt_e  out  2  E-stage rt bypass, same encoding.
- fwd_rt_m  out  1  M-stage rt (sw data) bypass: 0 = pipeline reg, 1 = W.
- md_busy  out  1  multiply/divide unit busy.

Behaviour:
- Decoding uses op = IR_D[31:26] and func = IR_D[5:0].
  - Class set: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, mult, div, mfhi, mflo, nop.
  - Unrecognised encodings behave as nop.
- Tuse per source:
  - Tuse = 0: beq rs/rt; jr rs.
  - Tuse = 1: addu/subu rs/rt; ori/lw/sw rs; mult/div rs/rt.
  - Tuse = 2: sw rt.
  - Sources an instruction does not read impose no constraint.
- A3 and Tnew on entry to E:
  - addu/subu/mfhi/mflo: A3 = rd, Tnew = 1.
  - ori/lui: A3 = rt, Tnew = 1.
  - lw: A3 = rt, Tnew = 2.
  - jal: A3 = 31, Tnew = 0.
  - All others: A3 = 0, Tnew = 0.
- Stage shift at each clk edge:
  - E gets D's decode, or a bubble (A3 = 0, Tnew = 0, sources 0) if stall = 1.
  - M gets E; W gets M.
  - Tnew decrements on each shift and saturates at 0.
- Register hazard stall (combinational):
  - Asserted if, for stage X in {E, M}, a D source satisfies src != 0, src == A3_X and Tnew_X > Tuse.
  - Register 0 never matches.
- MD stall (combinational):
  - Asserted if D is mult/div/mfhi/mflo and md_busy = 1.
  - stall is the OR of the register hazard stall and the MD stall.
- MD busy counter:
  - Loads MULT_CYCLES or DIV_CYCLES on the edge where a mult/div advances D->E (stall = 0).
  - Otherwise decrements while nonzero; holds at 0.
  - md_busy = (cnt != 0).
- Forwarding rules:
  - Forwarding is allowed only from a stage with Tnew = 0, A3 != 0 and A3 == src.
  - When several stages match, the youngest wins: E > M > W.
  - Forwarding from E is permitted for D sources only, and requires Tnew_E = 0 (jal).
  - E-stage sources check M, then W.
  - fwd_rt_m checks W only.
- All outputs are combinational from state and IR_D.
- Reset (reset = 0, asynchronous, checked before clk):
  - Clears all stage state and the counter.
  - With IR_D = 0, every output is 0.
  - Reset asserted mid-stall drops stall immediately, without waiting for a clock edge.
- Latency: zero-cycle decisions; state is updated only on clk.

Test Plan:
- lw $1,0($0) then addu $2,$1,$1 -> stall = 1 for exactly 1 cycle. Next cycle stall = 0. When addu is in E and lw in W, fwd_rs_e = fwd_rt_e = 3.
- addu $3,$1,$2 then beq $3,$3 -> stall = 1 for 1 cycle. Next cycle fwd_rs_d = fwd_rt_d = 2, stall = 0.
- jal then jr $31 -> stall = 0, fwd_rs_d = 1. One cycle later (jal in M), fwd_rs_d = 2.
- ori $0,$0,5 then beq $0,$0 -> stall = 0, fwd_rs_d = fwd_rt_d = 0. addu $4 then sw $4,0($0) -> no stall, fwd_rt_e = 2, then fwd_rt_m = 1.
- mult $1,$2 then mflo $5 -> md_busy high 5 cycles, stall = 1 for 5 cycles, mflo advances on cycle 6. div then div -> second div stalls 10 cycles.
- Assert reset = 0 asynchronously mid-div (cnt = 7, IR_D = mfhi) -> md_busy and stall fall to 0 before the next clk edge. After release, all fwd outputs are 0 with IR_D = 0.
